// File: rtl/gcbp_pkg.sv
// gcbp_pkg: geometry constants and capture FSM encoding shared by the GCBP line generator
// and the GCBP BRAM writer.
package gcbp_pkg;

    localparam int C_SUBIMAGE_WIDTH     = 128;
    localparam int C_SUBIMAGE_HEIGHT    = 128;
    localparam int C_NUM_HORI_SUBIMAGES = 4;
    localparam int C_LINES_PER_FRAME    = 480;
    localparam int C_VERT_OFFSET        = 176;

    localparam int C_LINE_CNT_W = 9;
    localparam int C_ROW_W      = 7;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SKIP    = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } gcbp_state_e;

    // Row inside the capture window for a frame line, wrapped to the BRAM row width.
    function automatic logic [C_ROW_W-1:0] line_to_row(
        input logic [C_LINE_CNT_W-1:0] line,
        input logic [C_LINE_CNT_W-1:0] offset
    );
        logic [C_LINE_CNT_W-1:0] diff;
        diff = line - offset;
        return diff[C_ROW_W-1:0];
    endfunction

endpackage

// File: rtl/gcbp_seq_check.sv
// gcbp_seq_check: flags sub-image indices that break the 0,1,2,3 order within a line while
// a capture is in progress. The flag is sticky until reset.
module gcbp_seq_check (
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic       i_frame_start,
    input  logic       i_valid,
    input  logic [1:0] i_subimage,
    input  logic       i_capture,
    output logic       o_seq_err
);

    logic [1:0] expected_r;
    logic       accept_s;
    logic       mismatch_s;

    // A valid coinciding with a frame start is dropped by the writer, so it is not checked.
    always_comb begin
        accept_s   = i_valid & ~i_frame_start;
        mismatch_s = accept_s & i_capture & (i_subimage != expected_r);
    end

    // Expected index resynchronises to the index just seen, so one slip reports once.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            expected_r <= 2'd0;
            o_seq_err  <= 1'b0;
        end else begin
            if (i_frame_start) begin
                expected_r <= 2'd0;
            end else if (accept_s) begin
                expected_r <= i_subimage + 2'd1;
            end else begin
                expected_r <= expected_r;
            end
            if (mismatch_s) begin
                o_seq_err <= 1'b1;
            end else begin
                o_seq_err <= o_seq_err;
            end
        end
    end

endmodule

// File: rtl/gcbp_bram_writer.sv
// gcbp_bram_writer: writes the capture window of each frame into ping-pong banks of the
// per-sub-image BRAMs. Optional ordering checker: define GCBP_BRAM_WR_SEQ_CHECK_EN.
module gcbp_bram_writer #(
    parameter int C_SUBIMAGE_WIDTH     = gcbp_pkg::C_SUBIMAGE_WIDTH,
    parameter int C_SUBIMAGE_HEIGHT    = gcbp_pkg::C_SUBIMAGE_HEIGHT,
    parameter int C_NUM_HORI_SUBIMAGES = gcbp_pkg::C_NUM_HORI_SUBIMAGES,
    parameter int C_LINES_PER_FRAME    = gcbp_pkg::C_LINES_PER_FRAME,
    parameter int C_VERT_OFFSET        = gcbp_pkg::C_VERT_OFFSET
) (
    input  logic                            i_clk,
    input  logic                            i_resetn,
    input  logic                            i_frame_start,
    input  logic [C_SUBIMAGE_WIDTH-1:0]     i_gcbp_line,
    input  logic                            i_gcbp_line_valid,
    input  logic [1:0]                      i_hori_subimage_cnt,
    output logic [C_NUM_HORI_SUBIMAGES-1:0] o_bram_we,
    output logic [7:0]                      o_bram_addr,
    output logic [C_SUBIMAGE_WIDTH-1:0]     o_bram_wdata,
    output logic                            o_frame_ready,
    output logic                            o_ready_bank,
    output logic                            o_frame_abort,
    output logic                            o_seq_err
);

    import gcbp_pkg::*;

    localparam logic [1:0]              LAST_SUB  = 2'(C_NUM_HORI_SUBIMAGES - 1);
    localparam logic [C_LINE_CNT_W-1:0] LINE_MAX  = C_LINE_CNT_W'(C_LINES_PER_FRAME - 1);
    localparam logic [C_LINE_CNT_W-1:0] SKIP_LAST = C_LINE_CNT_W'(C_VERT_OFFSET - 1);
    localparam logic [C_LINE_CNT_W-1:0] OFFSET    = C_LINE_CNT_W'(C_VERT_OFFSET);
    localparam logic [C_ROW_W-1:0]      ROW_LAST  = C_ROW_W'(C_SUBIMAGE_HEIGHT - 1);

    gcbp_state_e             state_r;
    logic [C_LINE_CNT_W-1:0] line_cnt_r;
    logic                    wr_bank_r;

    logic                    accept_s;
    logic                    line_end_s;
    logic                    counting_s;
    logic [C_ROW_W-1:0]      row_s;

    // Decode the current input; a frame start pre-empts any valid in the same cycle.
    always_comb begin
        accept_s   = i_gcbp_line_valid & ~i_frame_start;
        line_end_s = accept_s & (i_hori_subimage_cnt == LAST_SUB);
        counting_s = (state_r == S_SKIP) | (state_r == S_CAPTURE);
        row_s      = line_to_row(line_cnt_r, OFFSET);
    end

    // Capture FSM with line counter, bank ping-pong and registered BRAM/status outputs.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            state_r       <= S_IDLE;
            line_cnt_r    <= {C_LINE_CNT_W{1'b0}};
            wr_bank_r     <= 1'b0;
            o_bram_we     <= {C_NUM_HORI_SUBIMAGES{1'b0}};
            o_bram_addr   <= 8'd0;
            o_bram_wdata  <= {C_SUBIMAGE_WIDTH{1'b0}};
            o_frame_ready <= 1'b0;
            o_ready_bank  <= 1'b0;
            o_frame_abort <= 1'b0;
        end else begin
            o_bram_we     <= {C_NUM_HORI_SUBIMAGES{1'b0}};
            o_frame_ready <= 1'b0;
            o_frame_abort <= 1'b0;
            if (i_frame_start) begin
                // A restart mid-capture leaves the write bank in place so it is overwritten.
                state_r       <= S_SKIP;
                line_cnt_r    <= {C_LINE_CNT_W{1'b0}};
                o_frame_abort <= (state_r == S_CAPTURE);
            end else begin
                if (line_end_s && counting_s && (line_cnt_r != LINE_MAX)) begin
                    line_cnt_r <= line_cnt_r + 9'd1;
                end else begin
                    line_cnt_r <= line_cnt_r;
                end
                case (state_r)
                    S_IDLE: begin
                        state_r <= S_IDLE;
                    end
                    S_SKIP: begin
                        if (line_end_s && (line_cnt_r == SKIP_LAST)) begin
                            state_r <= S_CAPTURE;
                        end else begin
                            state_r <= S_SKIP;
                        end
                    end
                    S_CAPTURE: begin
                        if (accept_s) begin
                            o_bram_we[i_hori_subimage_cnt] <= 1'b1;
                            o_bram_addr  <= {wr_bank_r, row_s};
                            o_bram_wdata <= i_gcbp_line;
                            if (line_end_s && (row_s == ROW_LAST)) begin
                                o_frame_ready <= 1'b1;
                                o_ready_bank  <= wr_bank_r;
                                wr_bank_r     <= ~wr_bank_r;
                                state_r       <= S_DONE;
                            end else begin
                                state_r <= S_CAPTURE;
                            end
                        end else begin
                            state_r <= S_CAPTURE;
                        end
                    end
                    S_DONE: begin
                        state_r <= S_DONE;
                    end
                    default: begin
                        state_r <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef GCBP_BRAM_WR_SEQ_CHECK_EN
    gcbp_seq_check u_seq_check (
        .i_clk         (i_clk),
        .i_resetn      (i_resetn),
        .i_frame_start (i_frame_start),
        .i_valid       (i_gcbp_line_valid),
        .i_subimage    (i_hori_subimage_cnt),
        .i_capture     (state_r == S_CAPTURE),
        .o_seq_err     (o_seq_err)
    );
`else
    assign o_seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_gcbp_bram_writer.sv
// tb_gcbp_bram_writer: random line stimulus, frame-level reference model and a scoreboard
// that matches every write/ready/abort event the writer emits.
module tb_gcbp_bram_writer;

    localparam int OFF = 176;
    localparam int H   = 128;
    localparam int LPF = 480;
`ifdef GCBP_BRAM_WR_SEQ_CHECK_EN
    localparam logic SEQ_EXP = 1'b1;
`else
    localparam logic SEQ_EXP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         frame_start = 1'b0;
    logic [127:0] gcbp_line = 128'd0;
    logic         line_valid = 1'b0;
    logic [1:0]   sub_cnt = 2'd0;
    logic [3:0]   bram_we;
    logic [7:0]   bram_addr;
    logic [127:0] bram_wdata;
    logic         frame_ready;
    logic         ready_bank;
    logic         frame_abort;
    logic         seq_err;

    gcbp_bram_writer dut (
        .i_clk               (clk),
        .i_resetn            (resetn),
        .i_frame_start       (frame_start),
        .i_gcbp_line         (gcbp_line),
        .i_gcbp_line_valid   (line_valid),
        .i_hori_subimage_cnt (sub_cnt),
        .o_bram_we           (bram_we),
        .o_bram_addr         (bram_addr),
        .o_bram_wdata        (bram_wdata),
        .o_frame_ready       (frame_ready),
        .o_ready_bank        (ready_bank),
        .o_frame_abort       (frame_abort),
        .o_seq_err           (seq_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   we;
        logic [7:0]   addr;
        logic [127:0] data;
        logic         ready;
        logic         rb;
        logic         abort;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  n_writes = 0;

    // Reference model: frame progress measured in whole lines, bank as a frame-parity bit.
    bit m_active = 1'b0;
    bit m_done = 1'b0;
    int m_lines = 0;
    bit m_bank = 1'b0;
    bit m_ready_bank = 1'b0;

    task automatic mdl_frame_start();
        ev_t e;
        if (m_active && !m_done && m_lines >= OFF) begin
            e = '{we: 4'd0, addr: 8'd0, data: 128'd0, ready: 1'b0, rb: m_ready_bank, abort: 1'b1};
            exp_q.push_back(e);
        end
        m_active = 1'b1;
        m_done = 1'b0;
        m_lines = 0;
    endtask

    task automatic mdl_valid(input int s, input logic [127:0] d);
        ev_t e;
        bit fin;
        if (!m_active || m_done) return;
        if (m_lines >= OFF) begin
            fin = (s == 3) && (m_lines - OFF == H - 1);
            e.we = 4'd1 << s;
            e.addr = (m_bank ? 8'd128 : 8'd0) + 8'(m_lines - OFF);
            e.data = d;
            e.ready = fin;
            e.rb = fin ? m_bank : m_ready_bank;
            e.abort = 1'b0;
            exp_q.push_back(e);
            if (fin) begin
                m_ready_bank = m_bank;
                m_bank = !m_bank;
                m_done = 1'b1;
            end
        end
        if (s == 3 && m_lines < LPF - 1) m_lines++;
    endtask

    task automatic mdl_reset();
        m_active = 1'b0;
        m_done = 1'b0;
        m_lines = 0;
        m_bank = 1'b0;
        m_ready_bank = 1'b0;
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every cycle with a write, ready or abort consumes one expected event.
    always @(negedge clk) begin
        ev_t e;
        bit ok;
        if (bram_we != 4'd0 || frame_ready || frame_abort) begin
            if (bram_we != 4'd0) n_writes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event we=%b addr=%h ready=%b abort=%b", bram_we, bram_addr,
                         frame_ready, frame_abort);
            end else begin
                e = exp_q.pop_front();
                ok = (bram_we === e.we) && (frame_ready === e.ready) && (frame_abort === e.abort) &&
                     (ready_bank === e.rb);
                if (e.we != 4'd0) ok = ok && (bram_addr === e.addr) && (bram_wdata === e.data);
                if (!ok) begin
                    errors++;
                    $display("FAIL event got we=%b addr=%h data=%h rdy=%b rb=%b abort=%b expected we=%b addr=%h data=%h rdy=%b rb=%b abort=%b",
                             bram_we, bram_addr, bram_wdata, frame_ready, ready_bank, frame_abort,
                             e.we, e.addr, e.data, e.ready, e.rb, e.abort);
                end
            end
        end
    end

    task automatic drive(input logic fs, input logic v, input logic [1:0] s, input logic [127:0] d);
        frame_start = fs;
        line_valid = v;
        sub_cnt = s;
        gcbp_line = d;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        line_valid = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'd0, 128'd0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic send_sub(input int s);
        logic [127:0] d;
        if ($urandom_range(0, 3) == 0) idle();
        d = rnd128();
        mdl_valid(s, d);
        drive(1'b0, 1'b1, 2'(s), d);
    endtask

    task automatic send_line(input bit bad);
        for (int s = 0; s < 4; s++) begin
            if (!(bad && s == 1)) begin
                send_sub(s);
                if (bad && s == 2) chk("seq_err_set", {127'd0, seq_err}, {127'd0, SEQ_EXP});
            end
        end
    endtask

    task automatic start_frame();
        mdl_frame_start();
        drive(1'b1, 1'b0, 2'd0, 128'd0);
    endtask

    task automatic send_frame(input int nlines, input int bad_line);
        start_frame();
        for (int l = 0; l < nlines; l++) send_line(l == bad_line);
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        mdl_reset();
        repeat (2) idle();
        chk("rst_we", {124'd0, bram_we}, 128'd0);
        chk("rst_addr", {120'd0, bram_addr}, 128'd0);
        chk("rst_wdata", bram_wdata, 128'd0);
        chk("rst_ready", {127'd0, frame_ready}, 128'd0);
        chk("rst_ready_bank", {127'd0, ready_bank}, 128'd0);
        chk("rst_abort", {127'd0, frame_abort}, 128'd0);
        chk("rst_seq_err", {127'd0, seq_err}, 128'd0);
        resetn = 1'b1;
    endtask

    initial begin
        apply_reset();
        // Lines before any frame start must not write.
        for (int l = 0; l < 3; l++) send_line(1'b0);
        // Frame 1 into bank 0; frame 2 into bank 1.
        n_writes = 0;
        send_frame(LPF, -1);
        repeat (2) idle();
        chk("frame1_writes", 128'(n_writes), 128'd512);
        send_frame(LPF, -1);
        // Abort at capture row 60, then the next frame reuses bank 0.
        send_frame(OFF + 60, -1);
        send_sub(0);
        send_sub(1);
        send_frame(LPF, -1);
        // Collision: a sub-image-3 valid together with frame start is dropped.
        mdl_frame_start();
        drive(1'b1, 1'b1, 2'd3, rnd128());
        for (int l = 0; l < LPF; l++) send_line(l == OFF + 5);
        repeat (2) idle();
        chk("seq_err_held", {127'd0, seq_err}, {127'd0, SEQ_EXP});
        // Reset mid-capture, then a full frame lands in bank 0.
        send_frame(OFF + 30, -1);
        apply_reset();
        send_frame(LPF, -1);
        repeat (3) idle();
        chk("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
